// File: rtl/bop_crash_ctrl_pkg.sv
// Package bop_pkg: shared types for the heap-overflow crash controller.
// Contents: FSM state enum, incident cause encoding, incident log entry.
// No ports; imported by the interface, the incident FIFO and the top.
package bop_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2,
    CLEAR = 2'd3
  } crash_state_e;

  // CAUSE_NONE only exists as a reset value; logged entries are JAL or JALR.
  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    JAL        = 2'b01,
    JALR       = 2'b10
  } crash_cause_e;

  typedef struct packed {
    logic [31:0]  pc;
    crash_cause_e cause;
  } incident_t;

endpackage

// File: rtl/bop_crash_ctrl_if.sv
// Interface bop_crash_ctrl_if: groups every crash-controller signal except clock and reset.
// Ports: none; modport master = issuing core / trap side / detector, slave = the controller.
// Parameter CNT_W sizes the incident counter and must match the controller instance.
interface bop_crash_ctrl_if #(
  parameter int CNT_W = 16
) ();

  logic             en_i;
  logic             flag_i;
  logic             instr_valid_i;
  logic [31:0]      instr_pc_i;
  logic             is_jal_i;
  logic             is_jalr_i;
  logic             clr_i;
  logic             crash_req_o;
  logic             crash_ack_i;
  logic [31:0]      crash_pc_o;
  logic             rst_buf_o;
  logic [CNT_W-1:0] incident_cnt_o;
  logic             log_valid_o;
  logic [31:0]      log_pc_o;
  logic [1:0]       log_cause_o;
  logic             log_pop_i;
  logic             log_ovf_o;

  modport master (
    output en_i, flag_i, instr_valid_i, instr_pc_i, is_jal_i, is_jalr_i, clr_i,
    output crash_ack_i, log_pop_i,
    input  crash_req_o, crash_pc_o, rst_buf_o, incident_cnt_o,
    input  log_valid_o, log_pc_o, log_cause_o, log_ovf_o
  );

  modport slave (
    input  en_i, flag_i, instr_valid_i, instr_pc_i, is_jal_i, is_jalr_i, clr_i,
    input  crash_ack_i, log_pop_i,
    output crash_req_o, crash_pc_o, rst_buf_o, incident_cnt_o,
    output log_valid_o, log_pc_o, log_cause_o, log_ovf_o
  );

endinterface

// File: rtl/bop_crash_ctrl_incident_fifo.sv
// bop_incident_fifo: small FIFO of incident_t with drop-on-full and a sticky overflow bit.
// Ports: clk, rst (sync, active-high), flush, push/din, pop/dout, full, empty, ovf.
// A push onto a full FIFO is dropped unless a pop frees the slot in the same cycle.
module bop_incident_fifo
  import bop_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  incident_t din,
  input  logic      pop,
  output incident_t dout,
  output logic      full,
  output logic      empty,
  output logic      ovf
);

  localparam int AW = $clog2(DEPTH);

  incident_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;
  logic        do_push;
  logic        drop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop)    ovf    <= 1'b1;
    end
  end

  // Storage needs no reset: reads are only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/bop_crash_ctrl.sv
// bop_crash_ctrl: arms on the overflow detector's crash flag and raises a crash request when a
// JAL/JALR issues while still armed; holds it until acked, counts incidents, pulses rst_buf_o.
// Ports: clk_i, rst_i (sync, active-high), bus (bop_crash_ctrl_if.slave). Optional incident log
// is built only when BOP_CRASH_LOG_EN is defined; otherwise the log outputs are tied to 0.
module bop_crash_ctrl
  import bop_pkg::*;
#(
  parameter int ARM_WINDOW = 16,
  parameter int CNT_W      = 16,
  parameter int LOG_DEPTH  = 4
) (
  input logic clk_i,
  input logic rst_i,
  bop_crash_ctrl_if.slave bus
);

  localparam int WIN_W = $clog2(ARM_WINDOW + 1);

  crash_state_e     state_q, state_d;
  logic [WIN_W-1:0] window_q, window_d;
  logic [31:0]      pc_q, pc_d;
  crash_cause_e     cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ack_take;
  logic             in_fire;
  logic             in_clear;
  logic             is_jump;

  assign is_jump = bus.is_jal_i || bus.is_jalr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      window_q <= '0;
      pc_q     <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    pc_d     = pc_q;
    cause_d  = cause_q;
    ack_take = 1'b0;
    in_fire  = 1'b0;
    in_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en_i && bus.flag_i) begin
          state_d  = ARMED;
          window_d = WIN_W'(ARM_WINDOW);
        end
      end
      ARMED: begin
        // Losing enable or the flag disarms even if a jump issues the same cycle.
        if (!bus.en_i || !bus.flag_i) begin
          state_d = IDLE;
        end else if (bus.instr_valid_i && is_jump) begin
          // Checked before window expiry so a jump on the last slot still fires.
          state_d = FIRE;
          pc_d    = bus.instr_pc_i;
          cause_d = bus.is_jalr_i ? JALR : JAL;
        end else if (bus.instr_valid_i) begin
          window_d = window_q - WIN_W'(1);
          if (window_q <= WIN_W'(1)) state_d = IDLE;
        end
      end
      FIRE: begin
        in_fire = 1'b1;
        if (bus.crash_ack_i) begin
          state_d  = CLEAR;
          ack_take = 1'b1;
        end
      end
      CLEAR: begin
        in_clear = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.crash_req_o = in_fire;
  assign bus.crash_pc_o  = in_fire ? pc_q : 32'h0;
  assign bus.rst_buf_o   = in_clear;

  // Saturating incident counter; clr_i wins over a same-cycle ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (bus.clr_i) begin
      cnt_q <= '0;
    end else if (ack_take && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.incident_cnt_o = cnt_q;

`ifdef BOP_CRASH_LOG_EN
  incident_t log_head;
  incident_t log_din;
  logic      log_empty;
  logic      log_full_unused;
  logic      log_ovf;

  assign log_din = '{pc: pc_q, cause: cause_q};

  bop_incident_fifo #(
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (bus.clr_i),
    .push  (ack_take),
    .din   (log_din),
    .pop   (bus.log_pop_i),
    .dout  (log_head),
    .full  (log_full_unused),
    .empty (log_empty),
    .ovf   (log_ovf)
  );

  // Head is gated so stale storage never leaks out of an empty log.
  assign bus.log_valid_o = !log_empty;
  assign bus.log_pc_o    = log_empty ? 32'h0 : log_head.pc;
  assign bus.log_cause_o = log_empty ? 2'b00 : log_head.cause;
  assign bus.log_ovf_o   = log_ovf;
`else
  logic unused_log;
  assign unused_log      = ^{bus.log_pop_i, cause_q, 1'(LOG_DEPTH)};
  assign bus.log_valid_o = 1'b0;
  assign bus.log_pc_o    = 32'h0;
  assign bus.log_cause_o = 2'b00;
  assign bus.log_ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_bop_crash_ctrl.sv
module tb_bop_crash_ctrl;
  import bop_pkg::*;

  localparam int ARM_W = 16;
  localparam int DEPTH = 4;
`ifdef BOP_CRASH_LOG_EN
  localparam bit LOG_ON = 1'b1;
`else
  localparam bit LOG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  bop_crash_ctrl_if #(.CNT_W(16)) bus ();
  bop_crash_ctrl_if #(.CNT_W(2))  bus2 ();

  // Second instance sees identical stimulus; only its counter width differs.
  assign bus2.en_i          = bus.en_i;
  assign bus2.flag_i        = bus.flag_i;
  assign bus2.instr_valid_i = bus.instr_valid_i;
  assign bus2.instr_pc_i    = bus.instr_pc_i;
  assign bus2.is_jal_i      = bus.is_jal_i;
  assign bus2.is_jalr_i     = bus.is_jalr_i;
  assign bus2.clr_i         = bus.clr_i;
  assign bus2.crash_ack_i   = bus.crash_ack_i;
  assign bus2.log_pop_i     = bus.log_pop_i;

  bop_crash_ctrl #(.ARM_WINDOW(ARM_W), .CNT_W(16), .LOG_DEPTH(DEPTH)) u_dut (
    .clk_i (clk), .rst_i (rst), .bus (bus));
  bop_crash_ctrl #(.ARM_WINDOW(ARM_W), .CNT_W(2), .LOG_DEPTH(DEPTH)) u_dut2 (
    .clk_i (clk), .rst_i (rst), .bus (bus2));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: armed/request/pulse flags, instructions left, unbounded incident count.
  typedef struct { logic [31:0] pc; logic [1:0] cause; } ent_t;
  bit          m_armed, m_req, m_pulse, m_ovf;
  int          m_left, m_n;
  logic [31:0] m_pc;
  logic [1:0]  m_cause;
  ent_t        m_q[$];

  function automatic int sat(int n, int w);
    return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
  endfunction

  function automatic bit e_valid();
    return LOG_ON && (m_q.size() > 0);
  endfunction
  function automatic logic [31:0] e_pc();
    return e_valid() ? m_q[0].pc : 32'h0;
  endfunction
  function automatic logic [1:0] e_cause();
    return e_valid() ? m_q[0].cause : 2'b00;
  endfunction
  function automatic bit e_ovf();
    return LOG_ON && m_ovf;
  endfunction

  task automatic model_step();
    bit new_pulse, push, popped;
    new_pulse = 1'b0;
    push = 1'b0;
    if (rst) begin
      m_armed = 0; m_req = 0; m_pulse = 0; m_left = 0; m_n = 0; m_ovf = 0;
      m_q.delete();
      return;
    end
    if (m_req) begin
      if (bus.crash_ack_i) begin
        m_req = 0; new_pulse = 1; push = 1; m_n++;
      end
    end else if (m_pulse) begin
      // clear cycle: nothing can arm here
    end else if (!m_armed) begin
      if (bus.en_i && bus.flag_i) begin m_armed = 1; m_left = ARM_W; end
    end else begin
      if (!bus.en_i || !bus.flag_i) m_armed = 0;
      else if (bus.instr_valid_i && (bus.is_jal_i || bus.is_jalr_i)) begin
        m_armed = 0; m_req = 1; m_pc = bus.instr_pc_i;
        m_cause = bus.is_jalr_i ? 2'b10 : 2'b01;
      end else if (bus.instr_valid_i) begin
        m_left--;
        if (m_left == 0) m_armed = 0;
      end
    end
    m_pulse = new_pulse;
    if (bus.clr_i) begin
      m_n = 0; m_ovf = 0; m_q.delete();
    end else begin
      popped = bus.log_pop_i && (m_q.size() > 0);
      if (popped) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back('{pc: m_pc, cause: m_cause});
        else m_ovf = 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.en_i = 0; bus.flag_i = 0; bus.instr_valid_i = 0; bus.instr_pc_i = 0;
    bus.is_jal_i = 0; bus.is_jalr_i = 0; bus.clr_i = 0; bus.crash_ack_i = 0; bus.log_pop_i = 0;
  endtask

  // One complete incident: arm, jump, ack (optionally with clr/pop), clear cycle.
  task automatic do_crash(input logic [31:0] pc, input bit jal, input bit jalr,
                          input bit clr, input bit pop);
    idle_in(); bus.en_i = 1; bus.flag_i = 1; tick();
    bus.instr_valid_i = 1; bus.instr_pc_i = pc; bus.is_jal_i = jal; bus.is_jalr_i = jalr; tick();
    idle_in(); bus.crash_ack_i = 1; bus.clr_i = clr; bus.log_pop_i = pop; tick();
    idle_in(); tick();
  endtask

  task automatic test_reset();
    idle_in(); rst = 1; tick(); tick();
    checks++; if (bus.crash_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", bus.crash_req_o); end
    checks++; if (bus.rst_buf_o !== 1'b0) begin failures++; $display("FAIL reset_rst_buf got=%0b exp=0", bus.rst_buf_o); end
    checks++; if (bus.incident_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.incident_cnt_o); end
    checks++; if (bus.crash_pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus.crash_pc_o); end
    checks++; if (bus.log_valid_o !== 1'b0 || bus.log_ovf_o !== 1'b0) begin failures++; $display("FAIL reset_log got=%0b%0b exp=00", bus.log_valid_o, bus.log_ovf_o); end
    rst = 0;
  endtask

  task automatic test_basic();
    idle_in(); bus.en_i = 1; bus.flag_i = 1; tick();
    for (int i = 0; i < 3; i++) begin
      bus.instr_valid_i = 1; bus.instr_pc_i = $urandom; tick();
    end
    bus.instr_pc_i = 32'h80001234; bus.is_jalr_i = 1; tick();
    bus.instr_valid_i = 0; bus.is_jalr_i = 0;
    checks++; if (bus.crash_req_o !== 1'b1) begin failures++; $display("FAIL basic_req_rise got=%0b exp=1", bus.crash_req_o); end
    for (int i = 0; i < 5; i++) begin
      bus.flag_i = i[0]; bus.en_i = i[1]; tick();
      checks++; if (bus.crash_req_o !== 1'b1 || bus.crash_pc_o !== 32'h80001234) begin failures++; $display("FAIL basic_hold got=%0b/%h exp=1/80001234", bus.crash_req_o, bus.crash_pc_o); end
    end
    idle_in(); bus.crash_ack_i = 1; tick(); bus.crash_ack_i = 0;
    checks++; if (bus.crash_req_o !== 1'b0) begin failures++; $display("FAIL basic_req_drop got=%0b exp=0", bus.crash_req_o); end
    checks++; if (bus.incident_cnt_o !== 16'd1) begin failures++; $display("FAIL basic_cnt got=%0d exp=1", bus.incident_cnt_o); end
    checks++; if (bus.rst_buf_o !== 1'b1) begin failures++; $display("FAIL basic_rst_buf_on got=%0b exp=1", bus.rst_buf_o); end
    tick();
    checks++; if (bus.rst_buf_o !== 1'b0) begin failures++; $display("FAIL basic_rst_buf_off got=%0b exp=0", bus.rst_buf_o); end
  endtask

  task automatic test_window();
    idle_in(); bus.en_i = 1; bus.flag_i = 1; tick();
    bus.instr_valid_i = 1;
    for (int i = 0; i < ARM_W; i++) tick();
    bus.is_jal_i = 1; tick();
    checks++; if (bus.crash_req_o !== 1'b0) begin failures++; $display("FAIL window_expired_req got=%0b exp=0", bus.crash_req_o); end
    bus.is_jal_i = 0; bus.instr_valid_i = 0; tick();
    checks++; if (bus.crash_req_o !== 1'b0) begin failures++; $display("FAIL window_after_req got=%0b exp=0", bus.crash_req_o); end
    bus.flag_i = 0; tick();
    // Jump on the last slot of the window still fires.
    bus.flag_i = 1; tick();
    bus.instr_valid_i = 1;
    for (int i = 0; i < ARM_W - 1; i++) tick();
    bus.is_jal_i = 1; bus.instr_pc_i = 32'h0000_0ff0; tick();
    checks++; if (bus.crash_req_o !== 1'b1 || bus.crash_pc_o !== 32'h0000_0ff0) begin failures++; $display("FAIL window_last_slot got=%0b/%h exp=1/00000ff0", bus.crash_req_o, bus.crash_pc_o); end
    idle_in(); bus.crash_ack_i = 1; tick(); idle_in(); tick();
  endtask

  task automatic test_disarm();
    idle_in(); bus.en_i = 1; bus.flag_i = 1; tick();
    bus.flag_i = 0; tick();
    bus.instr_valid_i = 1; bus.is_jal_i = 1; tick();
    checks++; if (bus.crash_req_o !== 1'b0) begin failures++; $display("FAIL disarm_flag_fell got=%0b exp=0", bus.crash_req_o); end
    idle_in(); bus.flag_i = 1; bus.instr_valid_i = 1; bus.is_jal_i = 1; tick(); tick();
    checks++; if (bus.crash_req_o !== 1'b0) begin failures++; $display("FAIL disarm_en_low got=%0b exp=0", bus.crash_req_o); end
    idle_in(); bus.en_i = 1; bus.flag_i = 1; tick();
    bus.flag_i = 0; bus.instr_valid_i = 1; bus.is_jalr_i = 1; tick();
    checks++; if (bus.crash_req_o !== 1'b0) begin failures++; $display("FAIL disarm_same_cycle got=%0b exp=0", bus.crash_req_o); end
    idle_in(); tick();
  endtask

  task automatic test_rst_fire();
    idle_in(); bus.en_i = 1; bus.flag_i = 1; tick();
    bus.instr_valid_i = 1; bus.is_jal_i = 1; bus.instr_pc_i = 32'h1234_5678; tick();
    checks++; if (bus.crash_req_o !== 1'b1) begin failures++; $display("FAIL rstfire_req got=%0b exp=1", bus.crash_req_o); end
    idle_in(); rst = 1; bus.crash_ack_i = 1; tick(); rst = 0;
    checks++; if (bus.crash_req_o !== 1'b0 || bus.incident_cnt_o !== 16'd0) begin failures++; $display("FAIL rstfire_drop got=%0b/%0d exp=0/0", bus.crash_req_o, bus.incident_cnt_o); end
    tick();
    checks++; if (bus.crash_req_o !== 1'b0 || bus.rst_buf_o !== 1'b0 || bus.incident_cnt_o !== 16'd0) begin failures++; $display("FAIL rstfire_idle_ack got=%0b/%0b/%0d exp=0/0/0", bus.crash_req_o, bus.rst_buf_o, bus.incident_cnt_o); end
    bus.crash_ack_i = 0;
  endtask

  task automatic test_log_and_sat();
    for (int i = 1; i <= 5; i++) begin
      do_crash(32'h1000 + 32'(i) * 4, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (bus.incident_cnt_o !== 16'(i)) begin failures++; $display("FAIL log_cnt got=%0d exp=%0d", bus.incident_cnt_o, i); end
      checks++; if (bus2.incident_cnt_o !== 2'(sat(i, 2))) begin failures++; $display("FAIL sat_cnt got=%0d exp=%0d", bus2.incident_cnt_o, sat(i, 2)); end
    end
    checks++; if (bus.log_valid_o !== e_valid() || bus.log_pc_o !== e_pc() || bus.log_ovf_o !== e_ovf()) begin failures++; $display("FAIL log_full got=%0b/%h/%0b exp=%0b/%h/%0b", bus.log_valid_o, bus.log_pc_o, bus.log_ovf_o, e_valid(), e_pc(), e_ovf()); end
    do_crash(32'h2000, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.incident_cnt_o !== 16'd0 || bus2.incident_cnt_o !== 2'd0) begin failures++; $display("FAIL clr_cnt got=%0d/%0d exp=0/0", bus.incident_cnt_o, bus2.incident_cnt_o); end
    checks++; if (bus.log_valid_o !== 1'b0 || bus.log_ovf_o !== 1'b0) begin failures++; $display("FAIL clr_log got=%0b/%0b exp=0/0", bus.log_valid_o, bus.log_ovf_o); end
    // Fill, then push with a simultaneous pop on the full log.
    for (int i = 0; i < DEPTH; i++) do_crash(32'h3000 + 32'(i), i[0], ~i[0], 1'b0, 1'b0);
    do_crash(32'h3100, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (bus.log_ovf_o !== e_ovf() || bus.log_pc_o !== e_pc()) begin failures++; $display("FAIL log_pop_push got=%0b/%h exp=%0b/%h", bus.log_ovf_o, bus.log_pc_o, e_ovf(), e_pc()); end
    for (int i = 0; i < DEPTH + 1; i++) begin
      checks++; if (bus.log_valid_o !== e_valid() || bus.log_pc_o !== e_pc() || bus.log_cause_o !== e_cause()) begin failures++; $display("FAIL log_order got=%0b/%h/%0d exp=%0b/%h/%0d", bus.log_valid_o, bus.log_pc_o, bus.log_cause_o, e_valid(), e_pc(), e_cause()); end
      idle_in(); bus.log_pop_i = 1; tick();
    end
    idle_in(); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.en_i = ($urandom_range(0, 7) != 0);
      bus.flag_i = ($urandom_range(0, 3) != 0);
      bus.instr_valid_i = $urandom_range(0, 1);
      bus.instr_pc_i = $urandom;
      bus.is_jal_i = ($urandom_range(0, 5) == 0);
      bus.is_jalr_i = ($urandom_range(0, 5) == 0);
      bus.crash_ack_i = ($urandom_range(0, 2) == 0);
      bus.clr_i = ($urandom_range(0, 59) == 0);
      bus.log_pop_i = ($urandom_range(0, 3) == 0);
      tick();
      checks++; if (bus.crash_req_o !== m_req || bus.rst_buf_o !== m_pulse) begin failures++; $display("FAIL rand_ctrl cyc=%0d got=%0b/%0b exp=%0b/%0b", i, bus.crash_req_o, bus.rst_buf_o, m_req, m_pulse); end
      if (m_req) begin
        checks++; if (bus.crash_pc_o !== m_pc) begin failures++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", i, bus.crash_pc_o, m_pc); end
      end
      checks++; if (bus.incident_cnt_o !== 16'(sat(m_n, 16)) || bus2.incident_cnt_o !== 2'(sat(m_n, 2))) begin failures++; $display("FAIL rand_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i, bus.incident_cnt_o, bus2.incident_cnt_o, sat(m_n, 16), sat(m_n, 2)); end
      checks++; if (bus.log_valid_o !== e_valid() || bus.log_pc_o !== e_pc() || bus.log_cause_o !== e_cause() || bus.log_ovf_o !== e_ovf()) begin failures++; $display("FAIL rand_log cyc=%0d got=%0b/%h/%0d/%0b exp=%0b/%h/%0d/%0b", i, bus.log_valid_o, bus.log_pc_o, bus.log_cause_o, bus.log_ovf_o, e_valid(), e_pc(), e_cause(), e_ovf()); end
    end
    rst = 0; idle_in(); tick();
  endtask

  initial begin
    rst = 1;
    m_pc = '0; m_cause = '0;
    idle_in();
    test_reset();
    test_basic();
    test_window();
    test_disarm();
    test_rst_fire();
    test_log_and_sat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
